// File: rtl/pong_pkg.sv
// Shared geometry, widths and encodings for the pong ball logic.
package pong_pkg;
   localparam int COORD_W      = 10;
   localparam int H_RES        = 640;
   localparam int V_RES        = 480;
   localparam int BALL_SIZE    = 32;
   localparam int ROW_W        = $clog2(BALL_SIZE);
   localparam int SPEED        = 2;
   localparam int PAD_L_X      = 32;
   localparam int PAD_R_X      = 600;
   localparam int PAD_W        = 8;
   localparam int PAD_H        = 64;
   localparam int SERVE_FRAMES = 60;
   localparam int CNT_W        = $clog2(SERVE_FRAMES);

   localparam logic [COORD_W-1:0] CENTER_X = COORD_W'((H_RES - BALL_SIZE) / 2);
   localparam logic [COORD_W-1:0] CENTER_Y = COORD_W'((V_RES - BALL_SIZE) / 2);

   typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, MOVE = 2'd2, MISS = 2'd3} state_t;
   typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_x_t;
   typedef enum logic {DIR_DOWN  = 1'b0, DIR_UP   = 1'b1} dir_y_t;
endpackage

// File: rtl/ball_renderer.sv
// Scan-out side of the ball: box test against the beam, ROM row/column
// selection and the registered ball_on pixel flag.
module ball_renderer
   import pong_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [COORD_W-1:0] pixel_x,
   input  logic [COORD_W-1:0] pixel_y,
   input  logic [COORD_W-1:0] ball_x,
   input  logic [COORD_W-1:0] ball_y,
   input  logic [0:BALL_SIZE-1] rom_data,
   output logic [ROW_W-1:0]   rom_addr,
   output logic               ball_on
);
   logic [COORD_W-1:0] dx, dy;
   logic               in_box;

   // Modulo offsets: a beam left of / above the ball wraps large and fails the box test.
   assign dx       = pixel_x - ball_x;
   assign dy       = pixel_y - ball_y;
   assign in_box   = (dx < COORD_W'(BALL_SIZE)) && (dy < COORD_W'(BALL_SIZE));
   assign rom_addr = dy[ROW_W-1:0];

   // One-cycle pixel flag; the RGB path is delayed one clock to match.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ball_on <= 1'b0;
      else        ball_on <= in_box & rom_data[dx[ROW_W-1:0]];
   end
endmodule

// File: rtl/ball_motion_ctrl.sv
// Pong ball controller: serve/move/miss FSM, per-frame motion with wall and
// paddle bounces, and the ball bitmap renderer.
module ball_motion_ctrl
   import pong_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [COORD_W-1:0] pixel_x,
   input  logic [COORD_W-1:0] pixel_y,
   input  logic               frame_tick,
   input  logic               serve,
   input  logic [COORD_W-1:0] pad_l_y,
   input  logic [COORD_W-1:0] pad_r_y,
   output logic [ROW_W-1:0]   rom_addr,
   input  logic [0:BALL_SIZE-1] rom_data,
   output logic               ball_on,
   output logic [COORD_W-1:0] ball_x,
   output logic [COORD_W-1:0] ball_y,
   output logic               hit,
   output logic               point_l,
   output logic               point_r,
   output state_t             state
);
   localparam logic [COORD_W-1:0] STEP     = COORD_W'(SPEED);
   localparam logic [COORD_W-1:0] X_L_FACE = COORD_W'(PAD_L_X + PAD_W);
   localparam logic [COORD_W-1:0] X_R_FACE = COORD_W'(PAD_R_X - BALL_SIZE);
   localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(H_RES - BALL_SIZE);
   localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(V_RES - BALL_SIZE);
   localparam logic [COORD_W:0]   SZ_E     = (COORD_W+1)'(BALL_SIZE);
   localparam logic [COORD_W:0]   PH_E     = (COORD_W+1)'(PAD_H);

   state_t             state_nx;
   dir_x_t             dir_x, dir_x_nx;
   dir_y_t             dir_y, dir_y_nx;
   logic [COORD_W-1:0] x_nx, y_nx;
   logic [CNT_W-1:0]   srv_cnt, srv_cnt_nx;
   logic               hit_nx, point_l_nx, point_r_nx;
   logic               ovl_l, ovl_r;

   // Vertical overlap in one extra bit so pad_y + PAD_H cannot wrap.
   assign ovl_l = ({1'b0, ball_y} + SZ_E > {1'b0, pad_l_y}) && ({1'b0, ball_y} < {1'b0, pad_l_y} + PH_E);
   assign ovl_r = ({1'b0, ball_y} + SZ_E > {1'b0, pad_r_y}) && ({1'b0, ball_y} < {1'b0, pad_r_y} + PH_E);

   // Next state, motion and pulses; bounds are tested before any subtract so positions never wrap.
   always_comb begin
      state_nx   = state;
      x_nx       = ball_x;
      y_nx       = ball_y;
      dir_x_nx   = dir_x;
      dir_y_nx   = dir_y;
      srv_cnt_nx = srv_cnt;
      hit_nx     = 1'b0;
      point_l_nx = 1'b0;
      point_r_nx = 1'b0;
      case (state)
         IDLE: begin
            if (serve) begin
               state_nx   = SERVE;
               srv_cnt_nx = '0;
            end
         end
         SERVE: begin
            if (frame_tick) begin
               if (srv_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                  state_nx   = MOVE;
                  srv_cnt_nx = '0;
               end else begin
                  srv_cnt_nx = srv_cnt + 1'b1;
               end
            end
         end
         MOVE: begin
            if (frame_tick) begin
               if (dir_y == DIR_UP) begin
                  if (ball_y <= STEP) begin
                     y_nx     = '0;
                     dir_y_nx = DIR_DOWN;
                  end else begin
                     y_nx = ball_y - STEP;
                  end
               end else if (ball_y >= Y_MAX - STEP) begin
                  y_nx     = Y_MAX;
                  dir_y_nx = DIR_UP;
               end else begin
                  y_nx = ball_y + STEP;
               end

               if (dir_x == DIR_LEFT) begin
                  if (ball_x <= X_L_FACE + STEP && ovl_l) begin
                     x_nx     = X_L_FACE;
                     dir_x_nx = DIR_RIGHT;
                     hit_nx   = 1'b1;
                  end else if (ball_x <= STEP) begin
                     x_nx       = '0;
                     state_nx   = MISS;
                     point_r_nx = 1'b1;
                  end else begin
                     x_nx = ball_x - STEP;
                  end
               end else begin
                  if (ball_x >= X_R_FACE - STEP && ovl_r) begin
                     x_nx     = X_R_FACE;
                     dir_x_nx = DIR_LEFT;
                     hit_nx   = 1'b1;
                  end else if (ball_x >= X_MAX - STEP) begin
                     x_nx       = X_MAX;
                     state_nx   = MISS;
                     point_l_nx = 1'b1;
                  end else begin
                     x_nx = ball_x + STEP;
                  end
               end
            end
         end
         MISS: begin
            // Ball was heading at the loser, so flipping dir_x serves toward the scorer.
            if (frame_tick) begin
               x_nx       = CENTER_X;
               y_nx       = CENTER_Y;
               dir_x_nx   = (dir_x == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
               srv_cnt_nx = '0;
               state_nx   = SERVE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, position, direction, serve counter and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ball_x  <= CENTER_X;
         ball_y  <= CENTER_Y;
         dir_x   <= DIR_RIGHT;
         dir_y   <= DIR_DOWN;
         srv_cnt <= '0;
         hit     <= 1'b0;
         point_l <= 1'b0;
         point_r <= 1'b0;
      end else begin
         state   <= state_nx;
         ball_x  <= x_nx;
         ball_y  <= y_nx;
         dir_x   <= dir_x_nx;
         dir_y   <= dir_y_nx;
         srv_cnt <= srv_cnt_nx;
         hit     <= hit_nx;
         point_l <= point_l_nx;
         point_r <= point_r_nx;
      end
   end

   ball_renderer u_render (
      .clk      (clk),
      .rst_n    (rst_n),
      .pixel_x  (pixel_x),
      .pixel_y  (pixel_y),
      .ball_x   (ball_x),
      .ball_y   (ball_y),
      .rom_data (rom_data),
      .rom_addr (rom_addr),
      .ball_on  (ball_on)
   );
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: directed serve/bounce/miss scenarios plus a
// randomized paddle phase, all against a signed-integer game model.
module tb_ball_motion_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  pixel_x = '0, pixel_y = '0, pad_l_y = 10'd1000, pad_r_y = 10'd1000;
   logic        frame_tick = 1'b0, serve = 1'b0;
   logic [4:0]  rom_addr;
   logic [0:31] rom_data;
   logic        ball_on, hit, point_l, point_r;
   logic [9:0]  ball_x, ball_y;
   logic [1:0]  state;
   logic [0:31] rom_mem [32];
   bit          rom_full = 1'b0;
   int          total = 0, bad = 0;
   // game model: position, signed velocity, state 0..3, serve frame count
   int          mx, my, vx, vy, mst, mcnt;

   always #5 clk = ~clk;

   // ROM stand-in: combinational row lookup, or all-lit to probe the box edges.
   assign rom_data = rom_full ? '1 : rom_mem[rom_addr];

   ball_motion_ctrl dut (
      .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .frame_tick(frame_tick), .serve(serve), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
      .rom_addr(rom_addr), .rom_data(rom_data), .ball_on(ball_on),
      .ball_x(ball_x), .ball_y(ball_y), .hit(hit), .point_l(point_l),
      .point_r(point_r), .state(state)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Disc bitmap: centre (15.5,15.5), radius 16, in doubled coordinates.
   function automatic bit lit(input int r, input int c);
      return ((2*c-31)*(2*c-31) + (2*r-31)*(2*r-31)) <= 1024;
   endfunction

   function automatic bit exp_on(input int px, input int py);
      int dx, dy;
      dx = px - mx;
      dy = py - my;
      if (dx < 0 || dx >= 32 || dy < 0 || dy >= 32) return 1'b0;
      return rom_full ? 1'b1 : lit(dy, dx);
   endfunction

   task automatic model_reset();
      mx = 304; my = 224; vx = 2; vy = 2; mst = 0; mcnt = 0;
   endtask

   // One frame of the game rules, in plain signed arithmetic.
   task automatic model_tick(input int pl, input int pr, output bit eh, output bit epl, output bit epr);
      int nx, ny;
      bit ol, orr;
      eh = 0; epl = 0; epr = 0;
      case (mst)
         0: if (serve) begin mst = 1; mcnt = 0; end
         1: begin
            mcnt++;
            if (mcnt == 60) begin mst = 2; mcnt = 0; end
         end
         2: begin
            nx = mx + vx;
            ny = my + vy;
            if (ny <= 0) begin ny = 0; vy = 2; end
            else if (ny >= 448) begin ny = 448; vy = -2; end
            ol  = (my + 32 > pl) && (my < pl + 64);
            orr = (my + 32 > pr) && (my < pr + 64);
            if (vx < 0 && nx <= 40 && ol) begin nx = 40; vx = 2; eh = 1; end
            else if (vx > 0 && nx >= 568 && orr) begin nx = 568; vx = -2; eh = 1; end
            else if (nx <= 0) begin nx = 0; mst = 3; epr = 1; end
            else if (nx >= 608) begin nx = 608; mst = 3; epl = 1; end
            mx = nx;
            my = ny;
         end
         default: begin
            mx = 304; my = 224; vx = -vx; mst = 1; mcnt = 0;
         end
      endcase
   endtask

   task automatic tick(input int pl, input int pr);
      bit eh, epl, epr;
      @(negedge clk);
      pad_l_y = pl[9:0];
      pad_r_y = pr[9:0];
      frame_tick = 1'b1;
      model_tick(pl, pr, eh, epl, epr);
      @(posedge clk); #1;
      frame_tick = 1'b0;
      chk("ball_x", ball_x, mx);
      chk("ball_y", ball_y, my);
      chk("state", state, mst);
      chk("hit", hit, eh);
      chk("point_l", point_l, epl);
      chk("point_r", point_r, epr);
      @(posedge clk); #1;
      chk("pulse_width", {hit, point_l, point_r}, 0);
      repeat (2) @(posedge clk);
   endtask

   task automatic rchk(input string tag, input int px, input int py);
      @(negedge clk);
      pixel_x = px[9:0];
      pixel_y = py[9:0];
      @(posedge clk); #1;
      chk(tag, ball_on, exp_on(px, py));
   endtask

   task automatic run_until(input int target, input int maxf);
      for (int i = 0; i < maxf && mst != target; i++) tick(1000, 1000);
      chk("reach_state", state, target);
   endtask

   initial begin
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++) rom_mem[r][c] = lit(r, c);
      model_reset();

      // reset released between clock edges, serve low
      repeat (3) @(posedge clk);
      @(negedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_state", state, 0);
      chk("rst_x", ball_x, 304);
      chk("rst_y", ball_y, 224);
      chk("rst_ball_on", ball_on, 0);
      for (int i = 0; i < 5; i++) tick(1000, 1000);

      // render boundaries around the centred ball
      rchk("row1_col15", 319, 225);
      chk("row1_col15_lit", ball_on, 1);
      rchk("row1_col0", 304, 225);
      rom_full = 1'b1;
      rchk("wrap_left", 303, 224);
      rchk("box_tl", 304, 224);
      rchk("box_right_in", 335, 255);
      rchk("box_right_out", 336, 224);
      rchk("box_bot_out", 304, 256);
      rom_full = 1'b0;
      for (int i = 0; i < 30; i++)
         rchk("rnd_render", 300 + $urandom_range(0, 40), 220 + $urandom_range(0, 40));

      // serve coincident with frame_tick: enters SERVE, no motion, tick not counted
      @(negedge clk);
      serve = 1'b1;
      frame_tick = 1'b1;
      mst = 1; mcnt = 0;
      @(posedge clk); #1;
      serve = 1'b0;
      frame_tick = 1'b0;
      chk("serve_state", state, 1);
      chk("serve_x", ball_x, 304);
      for (int i = 0; i < 59; i++) begin
         serve = i[0];
         tick(1000, 1000);
      end
      serve = 1'b0;
      chk("serve_59", state, 1);
      tick(1000, 1000);
      chk("serve_60_move", state, 2);
      tick(1000, 1000);
      chk("first_move", {ball_x, ball_y}, {22'd0, 10'd306, 10'd226});

      // right miss after a floor bounce, then serve leftward
      run_until(3, 400);
      tick(1000, 1000);
      chk("miss_recentre", {ball_x, ball_y}, {22'd0, 10'd304, 10'd224});
      run_until(2, 70);
      for (int i = 0; i < 300 && !(mx == 42 && vx < 0); i++) tick(1000, 1000);
      chk("at_42", ball_x, 42);
      tick(my, 1000);
      chk("bounce_l_x", ball_x, 40);
      tick(1000, 1000);
      chk("bounce_l_dir", ball_x, 42);

      // right miss again, serve left, then a left-edge miss
      run_until(3, 400);
      tick(1000, 1000);
      run_until(2, 70);
      run_until(3, 400);
      chk("miss_l_x", ball_x, 0);
      tick(1000, 1000);
      run_until(2, 70);
      tick(1000, 1000);
      chk("serve_after_l_dir", ball_x, 306);

      // randomized paddles, half of them tracking the ball
      for (int i = 0; i < 600; i++) begin
         int pl, pr;
         pl = $urandom_range(0, 1023);
         pr = $urandom_range(0, 1023);
         if ($urandom_range(0, 1) == 1) begin
            pl = my + $urandom_range(0, 94) - 63;
            pr = my + $urandom_range(0, 94) - 63;
            if (pl < 0) pl = 0;
            if (pr < 0) pr = 0;
         end
         serve = 1'($urandom_range(0, 1));
         tick(pl, pr);
         if (i % 4 == 0)
            rchk("rnd_render_mv", mx - 4 + $urandom_range(0, 40), my - 4 + $urandom_range(0, 40));
      end
      serve = 1'b0;

      // async reset mid-cycle while moving, with a lit pixel under the beam
      run_until(2, 200);
      rchk("pre_rst_on", mx + 15, my + 1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst_state", state, 0);
      chk("arst_pos", {ball_x, ball_y}, {22'd0, 10'd304, 10'd224});
      chk("arst_outs", {ball_on, hit, point_l, point_r}, 0);
      model_reset();
      @(negedge clk); #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) tick(1000, 1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
